imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader: the write-side counterpart to the processor's read-only instruction memory. Takes framed bytes from the board's serial receiver, assembles 16-bit instruction words (high byte first), and writes them sequentially into the instruction RAM's write port starting at address 0. Holds the processor in reset while a load is in progress and reports success or checksum failure.

## Interface
- WIDTH, 16, instruction word width; only 16 is supported (two bytes per word)
- RAM_ADDR_BITS, 6, instruction RAM address width; maximum load is 2**RAM_ADDR_BITS words
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready
- we  out  1  instruction RAM write enable, one-cycle pulse per word
- wadr  out  RAM_ADDR_BITS  instruction RAM write address
- wdata  out  WIDTH  instruction word to write
- cpu_hold  out  1  hold processor in reset
- done  out  1  last load completed with good checksum (sticky)
- error  out  1  last load failed (sticky)
- word_count  out  RAM_ADDR_BITS+1  words written in current/last load

## Operation
- Frame: 0xA5 header, length byte N (words), 2N data bytes (hi, lo per word), checksum byte = XOR of N and all 2N data bytes.
- States: IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE: bytes other than 0xA5 are accepted and discarded. 0xA5 -> LEN; set cpu_hold; clear done, error, word_count, address counter, running checksum.
- LEN: N == 0 or N > 2**RAM_ADDR_BITS -> ERR; else latch N, checksum = N, -> HI.
- HI: latch high byte, fold into checksum, -> LO.
- LO: latch low byte, fold into checksum, -> WRITE.
- WRITE: we = 1, wadr = address counter, wdata = {hi, lo}. Increment word_count and address. -> CHK if word_count + 1 == N, else -> HI.
- CHK: received byte == running checksum -> DONE (done = 1, cpu_hold = 0); else -> ERR (error = 1, cpu_hold stays 1).
- DONE/ERR: accept and discard bytes; 0xA5 starts a new load exactly as from IDLE.
- Address never wraps: N is bounded, so the highest write address is 2**RAM_ADDR_BITS-1 and word_count maxes out at 2**RAM_ADDR_BITS.
- Failed loads leave the already-written words in RAM; no rollback.

## Timing
- All outputs registered, except rx_ready = rst_n && (state != WRITE).
- Reset values: we 0, wadr 0, wdata 0, cpu_hold 0, done 0, error 0, word_count 0, state IDLE.
- If the LO byte is accepted in cycle t, we is high in cycle t+1 with stable wadr/wdata. rx_ready is low in cycle t+1 and high again in t+2.
- Throughput is one byte per cycle, except for the one-cycle WRITE bubble after each word.
- cpu_hold rises the cycle after the 0xA5 header is accepted. It falls, and done rises, in the same cycle, the cycle after a matching checksum byte is accepted.
- rst_n low at any point, mid-frame included, returns the block to reset values on the next edge. A pending write is dropped.
- rx_valid may drop between bytes for any number of cycles; state holds and no byte is lost or duplicated.

## Test plan
- Stream A5 02 12 34 AB CD 42 back-to-back -> we pulses at adr 0 data 0x1234, then adr 1 data 0xABCD; done = 1, error = 0, cpu_hold 1 -> 0, word_count = 2.
- Same frame with checksum 0x43 -> both writes occur; error = 1, done = 0, cpu_hold stays 1. A following good frame -> done = 1, error = 0, cpu_hold = 0.
- A5 00, and separately A5 41 -> error = 1 the cycle after the length byte, no we pulse. Leading bytes 0x00 0xFF before A5 in IDLE -> ignored.
- Full 64-word load with word i = 0x0100+i -> addresses 0..63 written in order, word_count = 64, no write to a wrapped address, done = 1.
- Same 2-word frame with rx_valid randomly deasserted and held across the WRITE bubble -> identical writes and result; rx_ready low exactly one cycle after each LO byte.
- rst_n low for 1 cycle after A5 02 12 -> all outputs at reset values next cycle; a subsequent full frame loads correctly from adr 0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that writes 16-bit words into instruction RAM
module imem_loader #(
  parameter int WIDTH = 16,
  parameter int RAM_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     we,
  output logic [RAM_ADDR_BITS-1:0] wadr,
  output logic [WIDTH-1:0]         wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [RAM_ADDR_BITS:0]   word_count
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR} state_t;
  localparam logic [RAM_ADDR_BITS:0] ONE = (RAM_ADDR_BITS+1)'(1);
  state_t                 state;
  logic [7:0]             hi;
  logic [7:0]             chk;
  logic [RAM_ADDR_BITS:0] n;
  logic                   accept;
  logic                   last;
  assign rx_ready = rst_n && state != WRITE;
  assign accept   = rx_valid && rx_ready;
  assign last     = word_count + ONE == n;
  // frame sequencing, word assembly, RAM write pulse and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we         <= 1'b0;
      wadr       <= '0;
      wdata      <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      hi         <= '0;
      chk        <= '0;
      n          <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (accept && rx_data == 8'hA5) begin
          state      <= LEN;
          cpu_hold   <= 1'b1;
          done       <= 1'b0;
          error      <= 1'b0;
          word_count <= '0;
          wadr       <= '0;
          chk        <= '0;
        end
        LEN: if (accept) begin
          if (rx_data == 8'h00 || int'(rx_data) > (1 << RAM_ADDR_BITS)) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            n     <= rx_data[RAM_ADDR_BITS:0];
            chk   <= rx_data;
            state <= HI;
          end
        end
        HI: if (accept) begin
          hi    <= rx_data;
          chk   <= chk ^ rx_data;
          state <= LO;
        end
        LO: if (accept) begin
          we    <= 1'b1;
          wdata <= WIDTH'({hi, rx_data});
          chk   <= chk ^ rx_data;
          state <= WRITE;
        end
        WRITE: begin
          word_count <= word_count + ONE;
          wadr       <= last ? wadr : wadr + 1'b1;
          state      <= last ? CHK : HI;
        end
        CHK: if (accept) begin
          done     <= rx_data == chk;
          error    <= rx_data != chk;
          cpu_hold <= rx_data != chk;
          state    <= rx_data == chk ? DONE : ERR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-vector bench for the byte-stream instruction loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        we;
  logic [5:0]  wadr;
  logic [15:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  word_count;
  int          checks = 0;
  int          errs = 0;
  int          rdy_bad = 0;
  logic [21:0] wq[$];
  logic [15:0] fw[64];

  imem_loader #(.WIDTH(16), .RAM_ADDR_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .wadr(wadr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // log every RAM write and flag any cycle where rx_ready is not the inverse of we
  always @(negedge clk) begin
    if (rst_n && we) wq.push_back({wadr, wdata});
    if (rst_n && rx_ready == we) rdy_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int gap_of(input bit rnd);
    return rnd ? int'($urandom_range(0, 3)) : 0;
  endfunction

  task automatic send(input logic [7:0] b, input int gap = 0);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k == 10) check("rdy_timeout", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] cs, input bit rnd);
    send(8'hA5, gap_of(rnd));
    send(8'(n), gap_of(rnd));
    for (int i = 0; i < n; i++) begin
      send(fw[i][15:8], gap_of(rnd));
      send(fw[i][7:0], gap_of(rnd));
    end
    send(cs, gap_of(rnd));
  endtask

  task automatic check_writes(input int n);
    check("wr_count", wq.size(), n);
    for (int i = 0; i < n && i < wq.size(); i++)
      check($sformatf("wr%0d", i), wq[i], {6'(i), fw[i]});
    wq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", we, 0);
    check("rst_wadr", wadr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wc", word_count, 0);
    check("rst_ready", rx_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_up", rx_ready, 1);

    fw[0] = 16'h1234;
    fw[1] = 16'hABCD;
    send(8'h00);
    send(8'hFF);
    check("junk_hold", cpu_hold, 0);
    send(8'hA5);
    check("hdr_hold", cpu_hold, 1);
    send(8'h02);
    send(8'h12);
    send(8'h34);
    check("w0_we", we, 1);
    check("w0_adr", wadr, 0);
    check("w0_data", wdata, 16'h1234);
    check("w0_ready", rx_ready, 0);
    send(8'hAB);
    send(8'hCD);
    check("w1_we", we, 1);
    check("w1_adr", wadr, 1);
    check("w1_data", wdata, 16'hABCD);
    send(8'h42);
    check("a_done", done, 1);
    check("a_error", error, 0);
    check("a_hold", cpu_hold, 0);
    check("a_wc", word_count, 2);
    check_writes(2);

    send_frame(2, 8'h43, 1'b0);
    check("bad_error", error, 1);
    check("bad_done", done, 0);
    check("bad_hold", cpu_hold, 1);
    check_writes(2);
    send_frame(2, 8'h42, 1'b0);
    check("rec_done", done, 1);
    check("rec_error", error, 0);
    check("rec_hold", cpu_hold, 0);
    check_writes(2);

    send(8'hA5);
    send(8'h00);
    check("len0_error", error, 1);
    check("len0_hold", cpu_hold, 1);
    send(8'hA5);
    check("len41_clr", error, 0);
    send(8'h41);
    check("len41_error", error, 1);
    check("len41_done", done, 0);
    check_writes(0);

    for (int i = 0; i < 64; i++) fw[i] = 16'h0100 + 16'(i);
    send_frame(64, 8'h40, 1'b0);
    check("full_done", done, 1);
    check("full_error", error, 0);
    check("full_wc", word_count, 64);
    check("full_adr", wadr, 63);
    check_writes(64);

    fw[0] = 16'h1234;
    fw[1] = 16'hABCD;
    send_frame(2, 8'h42, 1'b1);
    check("rnd_done", done, 1);
    check("rnd_error", error, 0);
    check("rnd_wc", word_count, 2);
    check_writes(2);

    send(8'hA5);
    send(8'h02);
    send(8'h12);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_we", we, 0);
    check("mrst_wadr", wadr, 0);
    check("mrst_wdata", wdata, 0);
    check("mrst_hold", cpu_hold, 0);
    check("mrst_done", done, 0);
    check("mrst_error", error, 0);
    check("mrst_wc", word_count, 0);
    @(negedge clk) rst_n = 1'b1;
    send_frame(2, 8'h42, 1'b0);
    check("post_done", done, 1);
    check("post_hold", cpu_hold, 0);
    check("post_wc", word_count, 2);
    check_writes(2);

    repeat (2) @(negedge clk);
    check("rdy_vs_we", rdy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
